// File: rtl/kim_mem_access_ctrl.sv
// MEM-stage data-memory access controller: turns an EX/MEM load/store into a
// req/ack transaction, stalling the pipeline until ack or timeout.
module kim_mem_access_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  MemtoReg_reg,
  input  logic                  MemWrite_reg,
  input  logic [ADDR_WIDTH-1:0] alu_result_reg,
  input  logic [DATA_WIDTH-1:0] w_data_to_mem_reg,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  pipe_stall,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_valid,
  output logic                  bus_err,
  output logic [15:0]           stall_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state_reg, state_next;
  logic [7:0] wait_cnt_reg;
  logic       access;
  logic       timeout_hit;
  logic       start;
  logic       finish_ack;
  logic       finish_to;

  assign access      = MemtoReg_reg | MemWrite_reg;
  assign timeout_hit = (wait_cnt_reg == WAIT_LAST);
  // mem_we is held after the transaction, so it still tags the access in DONE
  assign load_valid  = (state_reg == DONE) & ~mem_we;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    pipe_stall = 1'b0;
    start      = 1'b0;
    finish_ack = 1'b0;
    finish_to  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (access) begin
          pipe_stall = 1'b1;
          start      = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        pipe_stall = 1'b1;
        if (mem_ack) begin
          finish_ack = 1'b1;
          state_next = DONE;
        end else if (timeout_hit) begin
          finish_to  = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      load_data    <= '0;
      bus_err      <= 1'b0;
      wait_cnt_reg <= '0;
    end else begin
      if (start) begin
        mem_req      <= 1'b1;
        mem_we       <= MemWrite_reg;
        mem_addr     <= alu_result_reg;
        mem_wdata    <= w_data_to_mem_reg;
        wait_cnt_reg <= '0;
        // simultaneous read+write runs as a store but is flagged
        if (MemtoReg_reg && MemWrite_reg) bus_err <= 1'b1;
      end
      if (finish_ack) begin
        mem_req <= 1'b0;
        if (!mem_we) load_data <= mem_rdata;
      end
      if (finish_to) begin
        mem_req <= 1'b0;
        bus_err <= 1'b1;
        if (!mem_we) load_data <= '0;
      end
      if (state_reg == WAIT && !mem_ack && !timeout_hit)
        wait_cnt_reg <= wait_cnt_reg + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      stall_cnt <= '0;
    else if (pipe_stall && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end

endmodule

// File: tb/tb_kim_mem_access_ctrl.sv
// Directed scoreboard bench for kim_mem_access_ctrl; a second instance with a
// 3-cycle timeout shares the inputs for the short-timeout case.
module tb_kim_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        MemtoReg_reg, MemWrite_reg, mem_ack;
  logic [31:0] alu_result_reg, w_data_to_mem_reg, mem_rdata;

  logic        mem_req, mem_we, pipe_stall, load_valid, bus_err;
  logic [31:0] mem_addr, mem_wdata, load_data;
  logic [15:0] stall_cnt;

  logic        mem_req_t3, mem_we_t3, pipe_stall_t3, load_valid_t3, bus_err_t3;
  logic [31:0] mem_addr_t3, mem_wdata_t3, load_data_t3;
  logic [15:0] stall_cnt_t3;

  always #5 clk = ~clk;

  kim_mem_access_ctrl u_dut (
    .clk(clk), .rstn(rstn),
    .MemtoReg_reg(MemtoReg_reg), .MemWrite_reg(MemWrite_reg),
    .alu_result_reg(alu_result_reg), .w_data_to_mem_reg(w_data_to_mem_reg),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .pipe_stall(pipe_stall), .load_data(load_data), .load_valid(load_valid),
    .bus_err(bus_err), .stall_cnt(stall_cnt)
  );

  kim_mem_access_ctrl #(.TIMEOUT_CYCLES(3)) u_dut_t3 (
    .clk(clk), .rstn(rstn),
    .MemtoReg_reg(MemtoReg_reg), .MemWrite_reg(MemWrite_reg),
    .alu_result_reg(alu_result_reg), .w_data_to_mem_reg(w_data_to_mem_reg),
    .mem_req(mem_req_t3), .mem_we(mem_we_t3), .mem_addr(mem_addr_t3), .mem_wdata(mem_wdata_t3),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .pipe_stall(pipe_stall_t3), .load_data(load_data_t3), .load_valid(load_valid_t3),
    .bus_err(bus_err_t3), .stall_cnt(stall_cnt_t3)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] ldata;
    logic        lvalid;
    logic        err;
    int          waits;
    int          stall;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_ldata;
  logic        m_err;
  int          m_stall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drops inputs with reset (the EX/MEM register is reset too) and checks
  // that every output is at its reset value while rstn is still low.
  task automatic do_reset();
    rstn = 1'b0;
    MemtoReg_reg = 1'b0; MemWrite_reg = 1'b0; mem_ack = 1'b0;
    alu_result_reg = '0; w_data_to_mem_reg = '0; mem_rdata = '0;
    m_ldata = '0; m_err = 1'b0; m_stall = 0;
    sb.delete();
    #1;
    check("rst_req",    {31'd0, mem_req},    32'd0);
    check("rst_we",     {31'd0, mem_we},     32'd0);
    check("rst_addr",   mem_addr,            32'd0);
    check("rst_wdata",  mem_wdata,           32'd0);
    check("rst_stall",  {31'd0, pipe_stall}, 32'd0);
    check("rst_ldata",  load_data,           32'd0);
    check("rst_lvalid", {31'd0, load_valid}, 32'd0);
    check("rst_err",    {31'd0, bus_err},    32'd0);
    check("rst_scnt",   {16'd0, stall_cnt},  32'd0);
    check("rst_t3_req", {31'd0, mem_req_t3}, 32'd0);
    check("rst_t3_err", {31'd0, bus_err_t3}, 32'd0);
    @(posedge clk); #2;
    rstn = 1'b1;
    #1;
  endtask

  // One transaction; ack_k = WAIT cycle that acks (0 = never ack).
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int ack_k, input logic spurious, input logic chk_t3);
    exp_t e;
    int   w;
    logic err_wait;
    e.we     = wr;
    e.addr   = addr;
    e.wdata  = wdata;
    e.waits  = (ack_k == 0) ? 15 : ack_k;
    e.lvalid = !wr;
    if (!wr) m_ldata = (ack_k == 0) ? 32'd0 : rdata;
    e.ldata  = m_ldata;
    err_wait = m_err | (rd & wr);
    m_err    = err_wait | (ack_k == 0);
    e.err    = m_err;
    m_stall  = m_stall + e.waits + 1;
    e.stall  = m_stall;
    sb.push_back(e);

    MemtoReg_reg = rd; MemWrite_reg = wr;
    alu_result_reg = addr; w_data_to_mem_reg = wdata;
    mem_ack = spurious; mem_rdata = 32'hBAD0_0BAD;
    #1;
    check("detect_stall", {31'd0, pipe_stall}, 32'd1);
    check("detect_req",   {31'd0, mem_req},    32'd0);
    w = 0;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    while (pipe_stall === 1'b1 && w < 40) begin
      w++;
      check("wait_req",    {31'd0, mem_req},    32'd1);
      check("wait_we",     {31'd0, mem_we},     {31'd0, wr});
      check("wait_addr",   mem_addr,            addr);
      check("wait_wdata",  mem_wdata,           wdata);
      check("wait_lvalid", {31'd0, load_valid}, 32'd0);
      check("wait_err",    {31'd0, bus_err},    {31'd0, err_wait});
      if (chk_t3 && w <= 3) check("t3_wait_req", {31'd0, mem_req_t3}, 32'd1);
      if (chk_t3 && w == 4) begin
        check("t3_done_req",    {31'd0, mem_req_t3},    32'd0);
        check("t3_done_stall",  {31'd0, pipe_stall_t3}, 32'd0);
        check("t3_done_lvalid", {31'd0, load_valid_t3}, 32'd1);
        check("t3_done_ldata",  load_data_t3,           32'd0);
        check("t3_done_err",    {31'd0, bus_err_t3},    32'd1);
        check("t3_done_scnt",   {16'd0, stall_cnt_t3},  32'd4);
      end
      mem_ack   = (w == ack_k);
      mem_rdata = (w == ack_k) ? rdata : 32'hBAD0_0BAD;
      @(posedge clk); #1;
    end
    mem_ack = 1'b0; mem_rdata = 32'hBAD0_0BAD;
    MemtoReg_reg = 1'b0; MemWrite_reg = 1'b0;

    e = sb.pop_front();
    check("done_waits",  w,                   e.waits);
    check("done_req",    {31'd0, mem_req},    32'd0);
    check("done_lvalid", {31'd0, load_valid}, {31'd0, e.lvalid});
    check("done_ldata",  load_data,           e.ldata);
    check("done_err",    {31'd0, bus_err},    {31'd0, e.err});
    check("done_scnt",   {16'd0, stall_cnt},  e.stall);
    $display("[TB] txn we=%0b addr=%h waits=%0d ldata=%h err=%0b stall_cnt=%0d",
             e.we, e.addr, w, load_data, bus_err, stall_cnt);
    @(posedge clk); #1;
    check("idle_stall",  {31'd0, pipe_stall}, 32'd0);
    check("idle_lvalid", {31'd0, load_valid}, 32'd0);
    check("idle_ldata",  load_data,           e.ldata);
    check("idle_err",    {31'd0, bus_err},    {31'd0, e.err});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    @(posedge clk); #1;

    // no ack: t3 instance times out after 3 WAIT cycles, default after 15
    do_access(1'b1, 1'b0, 32'h0000_0080, 32'h0, 32'h0, 0, 1'b0, 1'b1);
    check("timeout_err_sticky", {31'd0, bus_err}, 32'd1);
    do_reset();

    do_access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 1, 1'b0, 1'b0);
    do_access(1'b0, 1'b1, 32'h0000_0100, 32'h1234_5678, 32'h0, 4, 1'b0, 1'b0);

    // reset on WAIT cycle 2 aborts the load
    MemtoReg_reg = 1'b1; alu_result_reg = 32'h0000_0048;
    @(posedge clk); #1;
    check("abort_w1_req", {31'd0, mem_req}, 32'd1);
    @(posedge clk); #1;
    check("abort_w2_req", {31'd0, mem_req}, 32'd1);
    do_reset();
    do_access(1'b1, 1'b0, 32'h0000_0044, 32'h0, 32'hCAFE_F00D, 2, 1'b0, 1'b0);

    // back-to-back load then store, spurious ack in the store's detect cycle
    do_access(1'b1, 1'b0, 32'h0000_0200, 32'h0, 32'h1111_2222, 1, 1'b0, 1'b0);
    do_access(1'b0, 1'b1, 32'h0000_0204, 32'h3333_4444, 32'h0, 2, 1'b1, 1'b0);

    // spurious ack with no access pending
    mem_ack = 1'b1; mem_rdata = 32'h5555_6666;
    #1;
    check("spur_stall", {31'd0, pipe_stall}, 32'd0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("spur_req",    {31'd0, mem_req},    32'd0);
    check("spur_lvalid", {31'd0, load_valid}, 32'd0);
    check("spur_ldata",  load_data,           m_ldata);
    check("spur_scnt",   {16'd0, stall_cnt},  m_stall);

    // read+write together: runs as a store, flags bus_err
    do_access(1'b1, 1'b1, 32'h0000_0300, 32'hA5A5_A5A5, 32'h0, 1, 1'b0, 1'b0);
    check("illegal_err_sticky", {31'd0, bus_err}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
